// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - 32-bit LFSR stream checker: self-sync, lock, error count, loss of lock
// Optional macro LFSR_CHECKER_FIXED_SEED_EN: start locked against the generator reset seed.
module lfsr_stream_checker #(
  parameter int SYNC_WORDS     = 2,
  parameter int LOSS_THRESHOLD = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int RUN_MAX = (SYNC_WORDS > LOSS_THRESHOLD) ? SYNC_WORDS : LOSS_THRESHOLD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [31:0]          SEED    = 32'hA23A27BB;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [31:0]      exp_word;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             match;
  logic             sync_hit;
  logic             loss_hit;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  assign match    = (in_data == exp_word);
  assign run_inc  = run + 1'b1;
  assign sync_hit = (run_inc == RUN_W'(SYNC_WORDS));
  assign loss_hit = (run_inc == RUN_W'(LOSS_THRESHOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef LFSR_CHECKER_FIXED_SEED_EN
      exp_word <= SEED;
      state    <= LOCKED;
      locked   <= 1'b1;
`else
      exp_word <= 32'h0;
      state    <= HUNT;
      locked   <= 1'b0;
`endif
      run         <= '0;
      err_pulse   <= 1'b0;
      lock_lost   <= 1'b0;
      word_count  <= '0;
      error_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        word_count  <= '0;
        error_count <= '0;
        lock_lost   <= 1'b0;
      end
      if (in_valid) begin
        case (state)
          HUNT: begin
            exp_word <= lfsr_next(in_data);
            run      <= '0;
            state    <= VERIFY;
          end
          VERIFY: begin
            exp_word <= lfsr_next(in_data);
            if (!match) begin
              run <= '0;
            end else if (sync_hit) begin
              state  <= LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run_inc;
            end
          end
          LOCKED: begin
            if (!clear && word_count != CNT_MAX)
              word_count <= word_count + 1'b1;
            if (match) begin
              exp_word <= lfsr_next(in_data);
              run      <= '0;
            end else begin
              // Flywheel: keep predicting from our own sequence so one bad word does not derail us.
              exp_word  <= lfsr_next(exp_word);
              err_pulse <= 1'b1;
              if (!clear && error_count != CNT_MAX)
                error_count <= error_count + 1'b1;
              if (loss_hit) begin
                state     <= HUNT;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                run       <= '0;
              end else begin
                run <= run_inc;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb/tb_lfsr_stream_checker.sv - scoreboard bench for lfsr_stream_checker (default and sat instances)
module tb_lfsr_stream_checker;

  localparam logic [31:0] SEED = 32'hA23A27BB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        locked, err_pulse, lock_lost;
  logic [31:0] word_count, error_count;
  logic        sat_locked, sat_err, sat_lost;
  logic [3:0]  sat_wc, sat_ec;

  int checks = 0;
  int failures = 0;
  logic [31:0] gen;

  typedef struct packed {
    logic [31:0] exp;
    logic [1:0]  st;
    logic [7:0]  run;
    logic        locked;
    logic        errp;
    logic        lost;
    logic [31:0] wc;
    logic [31:0] ec;
  } mdl_t;

  mdl_t m_def, m_sat;
  mdl_t q_def[$];
  mdl_t q_sat[$];

  always #5 clk = ~clk;

  lfsr_stream_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
    .word_count(word_count), .error_count(error_count)
  );

  lfsr_stream_checker #(.SYNC_WORDS(2), .LOSS_THRESHOLD(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(sat_locked), .err_pulse(sat_err), .lock_lost(sat_lost),
    .word_count(sat_wc), .error_count(sat_ec)
  );

  function automatic logic [31:0] nx(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit c, input bit v,
                                 input logic [31:0] d, input int loss, input logic [31:0] cmax);
    mdl_t n;
    bit cw, ce, setl;
    n = m; n.errp = 1'b0; cw = 0; ce = 0; setl = 0;
    if (r) begin
      n = '0;
`ifdef LFSR_CHECKER_FIXED_SEED_EN
      n.exp = SEED; n.st = 2'd2; n.locked = 1'b1;
`endif
      return n;
    end
    if (v) begin
      case (m.st)
        2'd0: begin n.exp = nx(d); n.run = 8'd0; n.st = 2'd1; end
        2'd1: begin
          n.exp = nx(d);
          if (d != m.exp) n.run = 8'd0;
          else if (int'(m.run) + 1 == 2) begin n.st = 2'd2; n.run = 8'd0; end
          else n.run = 8'(m.run + 8'd1);
        end
        default: begin
          cw = 1;
          if (d == m.exp) begin n.exp = nx(d); n.run = 8'd0; end
          else begin
            n.exp = nx(m.exp); ce = 1; n.errp = 1'b1;
            if (int'(m.run) + 1 == loss) begin n.st = 2'd0; n.run = 8'd0; setl = 1; end
            else n.run = 8'(m.run + 8'd1);
          end
        end
      endcase
    end
    n.locked = (n.st == 2'd2);
    if (c) begin
      n.wc = 32'd0; n.ec = 32'd0; n.lost = setl;
    end else begin
      if (setl) n.lost = 1'b1;
      if (cw && n.wc != cmax) n.wc = n.wc + 32'd1;
      if (ce && n.ec != cmax) n.ec = n.ec + 32'd1;
    end
    return n;
  endfunction

  task automatic step(input bit v, input logic [31:0] d, input bit c, input bit r);
    rst = r; clear = c; in_valid = v; in_data = d;
    m_def = mstep(m_def, r, c, v, d, 4, 32'hFFFFFFFF);
    m_sat = mstep(m_sat, r, c, v, d, 32, 32'd15);
    q_def.push_back(m_def);
    q_sat.push_back(m_sat);
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_good();
    step(1'b1, gen, 1'b0, 1'b0);
    gen = nx(gen);
  endtask

  task automatic send_flip();
    step(1'b1, gen ^ 32'h1, 1'b0, 1'b0);
    gen = nx(gen);
  endtask

  always @(negedge clk) begin
    mdl_t e, s;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      s = q_sat.pop_front();
      checks += 8;
      if (locked !== e.locked) begin failures++; $display("FAIL sb_locked: got %0b expected %0b t=%0t", locked, e.locked, $time); end
      if (err_pulse !== e.errp) begin failures++; $display("FAIL sb_err_pulse: got %0b expected %0b t=%0t", err_pulse, e.errp, $time); end
      if (lock_lost !== e.lost) begin failures++; $display("FAIL sb_lock_lost: got %0b expected %0b t=%0t", lock_lost, e.lost, $time); end
      if (word_count !== e.wc) begin failures++; $display("FAIL sb_word_count: got %0d expected %0d t=%0t", word_count, e.wc, $time); end
      if (error_count !== e.ec) begin failures++; $display("FAIL sb_error_count: got %0d expected %0d t=%0t", error_count, e.ec, $time); end
      if (sat_locked !== s.locked) begin failures++; $display("FAIL sb_sat_locked: got %0b expected %0b t=%0t", sat_locked, s.locked, $time); end
      if (sat_wc !== s.wc[3:0]) begin failures++; $display("FAIL sb_sat_wc: got %0d expected %0d t=%0t", sat_wc, s.wc, $time); end
      if (sat_ec !== s.ec[3:0]) begin failures++; $display("FAIL sb_sat_ec: got %0d expected %0d t=%0t", sat_ec, s.ec, $time); end
    end
  end

  task automatic test_reset();
    logic exp_lock;
`ifdef LFSR_CHECKER_FIXED_SEED_EN
    exp_lock = 1'b1;
`else
    exp_lock = 1'b0;
`endif
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    checks += 3;
    if (locked !== exp_lock) begin failures++; $display("FAIL reset_locked: got %0b expected %0b", locked, exp_lock); end
    if (word_count !== 32'd0 || error_count !== 32'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", word_count, error_count); end
    if (lock_lost !== 1'b0 || err_pulse !== 1'b0) begin failures++; $display("FAIL reset_flags: got %0b/%0b expected 0/0", lock_lost, err_pulse); end
  endtask

`ifdef LFSR_CHECKER_FIXED_SEED_EN
  task automatic test_fixed_seed();
    gen = SEED;
    send_good();
    checks += 2;
    if (err_pulse !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL seed_good: got err=%0b lock=%0b expected 0/1", err_pulse, locked); end
    if (word_count !== 32'd1) begin failures++; $display("FAIL seed_wc: got %0d expected 1", word_count); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hA23A27BA, 1'b0, 1'b0);
    checks += 2;
    if (err_pulse !== 1'b1) begin failures++; $display("FAIL seed_bad_pulse: got %0b expected 1", err_pulse); end
    if (error_count !== 32'd1) begin failures++; $display("FAIL seed_bad_ec: got %0d expected 1", error_count); end
  endtask
`else
  task automatic test_lock();
    gen = SEED;
    for (int i = 0; i < 8; i++) begin
      send_good();
      if (i == 1) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %0b expected 0", locked); end
      end
      if (i == 2) begin
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_third: got %0b expected 1", locked); end
      end
    end
    checks += 2;
    if (word_count !== 32'd5) begin failures++; $display("FAIL lock_wc: got %0d expected 5", word_count); end
    if (error_count !== 32'd0) begin failures++; $display("FAIL lock_ec: got %0d expected 0", error_count); end
  endtask

  task automatic test_single_error();
    send_flip();
    checks += 2;
    if (err_pulse !== 1'b1) begin failures++; $display("FAIL single_pulse: got %0b expected 1", err_pulse); end
    if (error_count !== 32'd1) begin failures++; $display("FAIL single_ec: got %0d expected 1", error_count); end
    send_good();
    checks += 2;
    if (err_pulse !== 1'b0) begin failures++; $display("FAIL flywheel_pulse: got %0b expected 0", err_pulse); end
    if (locked !== 1'b1 || error_count !== 32'd1) begin failures++; $display("FAIL flywheel_state: got lock=%0b ec=%0d expected 1/1", locked, error_count); end
  endtask

  task automatic test_loss();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b0);
      if (i == 2) begin
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL loss_early: got %0b expected 1", locked); end
      end
    end
    checks += 2;
    if (locked !== 1'b0 || lock_lost !== 1'b1) begin failures++; $display("FAIL loss_flags: got lock=%0b lost=%0b expected 0/1", locked, lock_lost); end
    if (error_count !== 32'd4) begin failures++; $display("FAIL loss_ec: got %0d expected 4", error_count); end
    for (int i = 0; i < 3; i++) send_good();
    checks++;
    if (locked !== 1'b1 || lock_lost !== 1'b1) begin failures++; $display("FAIL relock: got lock=%0b lost=%0b expected 1/1", locked, lock_lost); end
  endtask

  task automatic test_clear();
    send_flip(); send_good(); send_flip(); send_good();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks += 2;
    if (word_count !== 32'd0 || error_count !== 32'd0) begin failures++; $display("FAIL clear_counts: got %0d/%0d expected 0/0", word_count, error_count); end
    if (lock_lost !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL clear_flags: got lost=%0b lock=%0b expected 0/1", lock_lost, locked); end
    step(1'b1, gen ^ 32'h1, 1'b1, 1'b0);
    gen = nx(gen);
    checks++;
    if (err_pulse !== 1'b1 || error_count !== 32'd0) begin failures++; $display("FAIL clear_mismatch: got err=%0b ec=%0d expected 1/0", err_pulse, error_count); end
    send_good();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b1, 1'b0);
    checks++;
    if (lock_lost !== 1'b1 || error_count !== 32'd0 || locked !== 1'b0) begin failures++; $display("FAIL clear_loss: got lost=%0b ec=%0d lock=%0b expected 1/0/0", lock_lost, error_count, locked); end
    for (int i = 0; i < 4; i++) send_good();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b0 || word_count !== 32'd0) begin failures++; $display("FAIL midreset: got lock=%0b lost=%0b wc=%0d expected 0/0/0", locked, lock_lost, word_count); end
    for (int i = 0; i < 3; i++) send_good();
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL midreset_relock: got %0b expected 1", locked); end
  endtask

  task automatic test_gaps();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    gen = SEED;
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      send_good();
      if (i == 1 || i == 2) begin
        checks++;
        if (locked !== (i == 2)) begin failures++; $display("FAIL gaps_lock_%0d: got %0b expected %0b", i, locked, (i == 2)); end
      end
    end
    checks++;
    if (word_count !== 32'd7 || error_count !== 32'd0) begin failures++; $display("FAIL gaps_counts: got %0d/%0d expected 7/0", word_count, error_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      send_flip();
      send_good();
    end
    checks += 3;
    if (sat_ec !== 4'd15 || sat_wc !== 4'd15) begin failures++; $display("FAIL sat_counts: got %0d/%0d expected 15/15", sat_ec, sat_wc); end
    if (sat_locked !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL sat_locked: got %0b/%0b expected 1/1", sat_locked, locked); end
    if (error_count !== 32'd20) begin failures++; $display("FAIL sat_wide_ec: got %0d expected 20", error_count); end
  endtask
`endif

  initial begin
    m_def = '0;
    m_sat = '0;
    gen = SEED;
    test_reset();
`ifdef LFSR_CHECKER_FIXED_SEED_EN
    test_fixed_seed();
`else
    test_lock();
    test_single_error();
    test_loss();
    test_clear();
    test_gaps();
    test_saturation();
`endif
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side counterpart of the 32-bit LFSR PRNG: checks an incoming word stream against the same LFSR recurrence.
- Self-synchronises from the received data, declares lock, then counts mismatches and detects loss of lock.
- Sits at the consumer end of PRNG-driven datapaths and links, for built-in self-test and stream-integrity monitoring.

Parameters:
- SYNC_WORDS, 2: consecutive correctly predicted words after the seed word required to lock (≥1).
- LOSS_THRESHOLD, 4: consecutive mismatches while locked that drop lock (≥1).
- CNT_WIDTH, 32: width of the word and error counters; both saturate.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear of counters and sticky flag; FSM state is unaffected.
- in_valid  input  1  in_data is valid this cycle; checker is always ready, no backpressure.
- in_data  input  32  received PRNG word.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatched word while locked.
- lock_lost  output  1  sticky; set on a LOCKED→HUNT transition.
- word_count  output  CNT_WIDTH  words checked while locked (saturating).
- error_count  output  CNT_WIDTH  mismatches while locked (saturating).

Behaviour:
- Recurrence: next(x) = {x[30:0], x[31]^x[21]^x[1]^x[0]}. Taps are fixed, so the width is fixed at 32.
- Registers: exp[31:0], state, run counter, outputs. All outputs are registered.
- Reset values: every output is 0, exp = 0, state = HUNT, run = 0.
- rst has priority over everything. clear has priority over counter increments in the same cycle.
- Idle cycles (in_valid = 0) change nothing: no exp advance and no counts.
- HUNT, on in_valid:
  - exp ← next(in_data), run ← 0, go to VERIFY.
- VERIFY, on in_valid:
  - Match (in_data == exp): exp ← next(in_data), run ← run+1.
  - When run+1 == SYNC_WORDS: go to LOCKED, run ← 0.
  - Mismatch: reseed exp ← next(in_data), run ← 0, stay in VERIFY.
  - Nothing is counted in VERIFY.
- LOCKED, on in_valid:
  - word_count++ on every word.
  - Match: exp ← next(in_data), run ← 0.
  - Mismatch (flywheel): exp ← next(exp), error_count++, err_pulse = 1 next cycle, run ← run+1.
  - When run+1 == LOSS_THRESHOLD: go to HUNT, set lock_lost, run ← 0.
- Latency: locked, err_pulse and the counters update the cycle after the word that causes the change.
- Saturation: both counters hold at all-ones and do not wrap.
- clear and a mismatch in the same cycle: counters go to 0 and err_pulse still fires.
- clear and a lock loss in the same cycle: lock_lost ends up 1 (set wins over clear).

Optional Feature:
- Macro: LFSR_CHECKER_FIXED_SEED_EN.
- Defined:
  - Reset loads exp = 32'hA23A27BB and state = LOCKED, locked = 1, so the first word after reset is checked against the generator's reset seed.
  - On lock loss the block still enters HUNT and self-syncs normally.
- Undefined: behaviour as above (self-sync from HUNT).

Test Plan:
1. Default build. After rst, feed 0xA23A27BB, 0x44744F76, 0x88E89EEC, … on consecutive cycles → locked = 1 the cycle after the third word; word_count then increments per word; error_count = 0.
2. While locked, send one word with bit 0 flipped, then resume the correct sequence → one err_pulse, error_count = 1, the next correct word matches via flywheel, locked stays 1.
3. While locked, send 0x00000000 four times → error_count = 4; locked = 0 and lock_lost = 1 after the 4th word; a correct resync stream relocks and lock_lost stays 1.
4. Same stream as test 1 with random in_valid gaps of 0–3 cycles → identical lock point and counts; no errors.
5. clear while locked with error_count = 2 → counters = 0, lock_lost = 0, locked = 1. rst mid-stream → all outputs 0, and relock takes 3 words.
6. CNT_WIDTH = 4, locked, LOSS_THRESHOLD = 32, 20 single mismatches each separated by good words → error_count = 15 (saturated).
7. LFSR_CHECKER_FIXED_SEED_EN defined, first word 0xA23A27BB → no error, locked = 1 from reset. First word 0xA23A27BA → err_pulse, error_count = 1.
